vga_layer_scanner: RTL and testbench

//   Parametrised frame renderer between game logic and vga_adapter. Per frame request,

---
 rtl/vls_pkg.sv | 16 +
 rtl/vls_priority_mux.sv | 22 ++
 rtl/vga_layer_scanner.sv | 156 +++++++++++++++
 tb/tb_vga_layer_scanner.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/vls_pkg.sv
// Shared types and constants for the vga_layer_scanner frame renderer.
package vls_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SCAN  = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } state_t;

   localparam int unsigned FRAME_CNT_W       = 16;
   localparam int unsigned DEF_COLOUR_W      = 9;
   localparam logic [DEF_COLOUR_W-1:0] DEF_BG_COLOUR     = 9'h000;
   localparam logic [DEF_COLOUR_W-1:0] DEF_BORDER_COLOUR = 9'h1FF;

endpackage

// File: rtl/vls_priority_mux.sv
// Lowest-index-wins layer colour select with background fallback.
module vls_priority_mux #(
   parameter int unsigned NUM_LAYERS = 4,
   parameter int unsigned COLOUR_W   = 9,
   parameter logic [COLOUR_W-1:0] BG_COLOUR = '0
) (
   input  logic [NUM_LAYERS-1:0]          hit,
   input  logic [NUM_LAYERS*COLOUR_W-1:0] colours,
   output logic [COLOUR_W-1:0]            colour_c
);

   // Walk from lowest priority upward so the lowest set index overwrites last.
   always_comb begin
      colour_c = BG_COLOUR;
      for (int i = int'(NUM_LAYERS) - 1; i >= 0; i--) begin
         if (hit[i]) begin
            colour_c = colours[i*COLOUR_W +: COLOUR_W];
         end
      end
   end

endmodule

// File: rtl/vga_layer_scanner.sv
// Raster-scans a frame, resolves layer priority and emits one plot per pixel.
// Optional edge-pixel border override: define VLS_BORDER_EN.
module vga_layer_scanner
   import vls_pkg::*;
#(
   parameter int unsigned H_ACTIVE   = 160,
   parameter int unsigned V_ACTIVE   = 120,
   parameter int unsigned X_W        = 8,
   parameter int unsigned Y_W        = 7,
   parameter int unsigned COLOUR_W   = 9,
   parameter int unsigned NUM_LAYERS = 4,
   parameter logic [COLOUR_W-1:0] BG_COLOUR     = COLOUR_W'(DEF_BG_COLOUR),
   parameter logic [COLOUR_W-1:0] BORDER_COLOUR = COLOUR_W'(DEF_BORDER_COLOUR)
) (
   input  logic                           clk,
   input  logic                           resetn,
   input  logic                           frame_req,
   input  logic                           pause,
   output logic [X_W-1:0]                 query_x,
   output logic [Y_W-1:0]                 query_y,
   input  logic [NUM_LAYERS-1:0]          layer_hit,
   input  logic [NUM_LAYERS*COLOUR_W-1:0] layer_colour,
   output logic [X_W-1:0]                 x_out,
   output logic [Y_W-1:0]                 y_out,
   output logic [COLOUR_W-1:0]            colour_out,
   output logic                           plot,
   output logic                           frame_busy,
   output logic                           frame_done,
   output logic [FRAME_CNT_W-1:0]         frame_cnt
);

   localparam logic [X_W-1:0] X_LAST = X_W'(H_ACTIVE - 1);
   localparam logic [Y_W-1:0] Y_LAST = Y_W'(V_ACTIVE - 1);

   state_t state, next_state;

   logic                           s1_valid;
   logic [X_W-1:0]                 s1_x;
   logic [Y_W-1:0]                 s1_y;
   logic                           s1_held;
   logic [NUM_LAYERS-1:0]          s1_hit;
   logic [NUM_LAYERS*COLOUR_W-1:0] s1_colours;
   logic                           s2_valid;

   logic [NUM_LAYERS-1:0]          hit_sel_c;
   logic [NUM_LAYERS*COLOUR_W-1:0] colours_sel_c;
   logic [COLOUR_W-1:0]            mux_colour_c;
   logic [COLOUR_W-1:0]            resolved_c;

   always_ff @(posedge clk) begin
      if (!resetn) state <= IDLE;
      else         state <= next_state;
   end

   always_comb begin
      next_state = state;
      case (state)
         IDLE:    if (frame_req) next_state = SCAN;
         SCAN:    if (!pause && query_x == X_LAST && query_y == Y_LAST) next_state = DRAIN;
         DRAIN:   if (!pause && !s1_valid) next_state = DONE;
         DONE:    next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   // Query raster counters
   always_ff @(posedge clk) begin
      if (!resetn) begin
         query_x <= '0;
         query_y <= '0;
      end else if (state == IDLE && frame_req) begin
         query_x <= '0;
         query_y <= '0;
      end else if (state == SCAN && !pause) begin
         if (query_x == X_LAST) begin
            query_x <= '0;
            query_y <= (query_y == Y_LAST) ? '0 : Y_W'(query_y + 1'b1);
         end else begin
            query_x <= X_W'(query_x + 1'b1);
         end
      end
   end

   // Stage 1: layer answers are only live in the cycle right after the query,
   // so capture them on the first paused cycle to survive a long pause.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         s1_valid   <= 1'b0;
         s1_x       <= '0;
         s1_y       <= '0;
         s1_held    <= 1'b0;
         s1_hit     <= '0;
         s1_colours <= '0;
      end else if (!pause) begin
         s1_valid <= (state == SCAN);
         s1_x     <= query_x;
         s1_y     <= query_y;
         s1_held  <= 1'b0;
      end else if (!s1_held) begin
         s1_held    <= 1'b1;
         s1_hit     <= layer_hit;
         s1_colours <= layer_colour;
      end
   end

   assign hit_sel_c     = s1_held ? s1_hit : layer_hit;
   assign colours_sel_c = s1_held ? s1_colours : layer_colour;

   vls_priority_mux #(
      .NUM_LAYERS (NUM_LAYERS),
      .COLOUR_W   (COLOUR_W),
      .BG_COLOUR  (BG_COLOUR)
   ) u_priority_mux (
      .hit      (hit_sel_c),
      .colours  (colours_sel_c),
      .colour_c (mux_colour_c)
   );

`ifdef VLS_BORDER_EN
   assign resolved_c = (s1_x == '0 || s1_x == X_LAST || s1_y == '0 || s1_y == Y_LAST)
                       ? BORDER_COLOUR : mux_colour_c;
`else
   assign resolved_c = mux_colour_c;
`endif

   // Stage 2: write-side registers
   always_ff @(posedge clk) begin
      if (!resetn) begin
         s2_valid   <= 1'b0;
         x_out      <= '0;
         y_out      <= '0;
         colour_out <= '0;
      end else if (!pause) begin
         s2_valid   <= s1_valid;
         x_out      <= s1_x;
         y_out      <= s1_y;
         colour_out <= resolved_c;
      end
   end

   // Plot must drop in the same cycle pause rises so the adapter never consumes a held pixel.
   assign plot = s2_valid & ~pause;

   always_ff @(posedge clk) begin
      if (!resetn) begin
         frame_busy <= 1'b0;
         frame_done <= 1'b0;
         frame_cnt  <= '0;
      end else begin
         frame_busy <= (next_state != IDLE);
         frame_done <= (next_state == DONE);
         if (next_state == DONE) frame_cnt <= FRAME_CNT_W'(frame_cnt + 1'b1);
      end
   end

endmodule

// File: tb/tb_vga_layer_scanner.sv
// Scoreboard bench for vga_layer_scanner on a 4x3 frame; honours VLS_BORDER_EN.
module tb_vga_layer_scanner;

   localparam int H  = 4;
   localparam int V  = 3;
   localparam int XW = 2;
   localparam int YW = 2;
   localparam int CW = 9;
   localparam int NL = 4;

   typedef struct packed {
      logic [XW-1:0] x;
      logic [YW-1:0] y;
      logic [CW-1:0] c;
   } pix_t;

   logic           clk = 1'b0;
   logic           resetn;
   logic           frame_req;
   logic           pause;
   logic [XW-1:0]  query_x;
   logic [YW-1:0]  query_y;
   logic [NL-1:0]  layer_hit = '0;
   logic [NL*CW-1:0] layer_colour;
   logic [XW-1:0]  x_out;
   logic [YW-1:0]  y_out;
   logic [CW-1:0]  colour_out;
   logic           plot;
   logic           frame_busy;
   logic           frame_done;
   logic [15:0]    frame_cnt;

   logic [NL-1:0]  base_hit;
   logic           diag_mode;
   logic [CW-1:0]  lc0, lc1, lc2, lc3;

   pix_t        exp_q[$];
   int          checks = 0;
   int          errors = 0;
   int          plots_seen = 0;
   int          done_seen = 0;
   int          cyc_n = 0;
   int          last_done_cyc = 0;
   int          prev_done_cyc = 0;
   logic [15:0] model_cnt = '0;

   vga_layer_scanner #(
      .H_ACTIVE   (H),
      .V_ACTIVE   (V),
      .X_W        (XW),
      .Y_W        (YW),
      .COLOUR_W   (CW),
      .NUM_LAYERS (NL)
   ) dut (
      .clk          (clk),
      .resetn       (resetn),
      .frame_req    (frame_req),
      .pause        (pause),
      .query_x      (query_x),
      .query_y      (query_y),
      .layer_hit    (layer_hit),
      .layer_colour (layer_colour),
      .x_out        (x_out),
      .y_out        (y_out),
      .colour_out   (colour_out),
      .plot         (plot),
      .frame_busy   (frame_busy),
      .frame_done   (frame_done),
      .frame_cnt    (frame_cnt)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc_n <= cyc_n + 1;

   // Layer model: answers one cycle after the query; layer 0 optionally hits on the diagonal.
   assign layer_colour = {lc3, lc2, lc1, lc0};
   always @(posedge clk)
      layer_hit <= base_hit | ((diag_mode && query_x == query_y) ? 4'b0001 : 4'b0000);

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Expected pixels for one frame in raster order.
   task automatic push_frame(input logic [CW-1:0] c, input logic [CW-1:0] diag_c, input bit diag);
      pix_t p;
      for (int y = 0; y < V; y++) begin
         for (int x = 0; x < H; x++) begin
            p.x = XW'(x);
            p.y = YW'(y);
            p.c = (diag && x == y) ? diag_c : c;
`ifdef VLS_BORDER_EN
            if (x == 0 || x == H-1 || y == 0 || y == V-1) p.c = 9'h1FF;
`endif
            exp_q.push_back(p);
         end
      end
   endtask

   task automatic wait_done(input int target, input string name);
      int n = 0;
      while (done_seen < target && n < 300) begin
         @(negedge clk);
         #1;
         n++;
      end
      chk({name, "_done_timeout"}, 64'(done_seen >= target), 64'(1));
   endtask

   task automatic start_frame(input bit pause_in_idle);
      @(negedge clk);
      frame_req = 1'b1;
      pause     = pause_in_idle;
      @(negedge clk);
      frame_req = 1'b0;
      pause     = 1'b0;
   endtask

   task automatic settle_and_check(input string name);
      repeat (4) @(negedge clk);
      chk({name, "_queue_empty"}, 64'(exp_q.size()), 64'(0));
      chk({name, "_frame_cnt"}, 64'(frame_cnt), 64'(model_cnt));
   endtask

   // Monitor: pops the scoreboard on every plot, tracks frame_done pulses.
   always @(negedge clk) begin
      pix_t e;
      if (plot) begin
         plots_seen++;
         chk("busy_during_plot", 64'(frame_busy), 64'(1));
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_plot: got (%0d,%0d) %0h expected none", x_out, y_out, colour_out);
         end else begin
            e = exp_q.pop_front();
            chk("pixel", 64'({x_out, y_out, colour_out}), 64'({e.x, e.y, e.c}));
         end
      end
      if (frame_done) begin
         done_seen++;
         prev_done_cyc = last_done_cyc;
         last_done_cyc = cyc_n;
         model_cnt = model_cnt + 16'd1;
         chk("frame_cnt_at_done", 64'(frame_cnt), 64'(model_cnt));
      end
   end

   initial begin
      int req_cyc;
      int base;
      int n;
      resetn    = 1'b0;
      frame_req = 1'b0;
      pause     = 1'b0;
      base_hit  = '0;
      diag_mode = 1'b0;
      lc0 = 9'h111; lc1 = 9'h0AA; lc2 = 9'h155; lc3 = 9'h0C3;

      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("reset_outputs", 64'({query_x, query_y, x_out, y_out, colour_out, plot,
                                frame_busy, frame_done, frame_cnt}), 64'(0));
      resetn = 1'b1;

      // 1: no hits, background everywhere, check done latency
      push_frame(9'h000, 9'h000, 1'b0);
      @(negedge clk);
      req_cyc   = cyc_n;
      frame_req = 1'b1;
      @(negedge clk);
      frame_req = 1'b0;
      wait_done(1, "t1");
      chk("t1_done_latency", 64'(last_done_cyc - req_cyc), 64'(15));
      settle_and_check("t1");
      chk("t1_cnt_one", 64'(frame_cnt), 64'(1));

      // 2: layers 1 and 2 hit -> layer 1 wins; request with pause high in IDLE
      base_hit = 4'b0110;
      push_frame(9'h0AA, 9'h000, 1'b0);
      start_frame(1'b1);
      wait_done(2, "t2a");
      settle_and_check("t2a");
      base_hit = 4'b1000;
      push_frame(9'h0C3, 9'h000, 1'b0);
      start_frame(1'b0);
      wait_done(3, "t2b");
      settle_and_check("t2b");

      // 3: pause 5 cycles with x=2 of row 1 waiting at the output; diagonal layer
      base_hit  = 4'b0010;
      diag_mode = 1'b1;
      push_frame(9'h0AA, 9'h111, 1'b1);
      start_frame(1'b0);
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!(plot && x_out == 2'd1 && y_out == 2'd1) && n < 100);
      chk("t3_found_x1", 64'(n < 100), 64'(1));
      @(posedge clk);
      #1 pause = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("t3_paused_plot_low", 64'(plot), 64'(0));
         chk("t3_paused_hold_x2", 64'({x_out, y_out}), 64'({2'd2, 2'd1}));
      end
      @(posedge clk);
      #1 pause = 1'b0;
      wait_done(4, "t3");
      settle_and_check("t3");
      diag_mode = 1'b0;

      // 4: reset mid-frame at pixel 7
      base_hit = 4'b0000;
      push_frame(9'h000, 9'h000, 1'b0);
      base = plots_seen;
      start_frame(1'b0);
      n = 0;
      while (plots_seen < base + 7 && n < 100) begin
         @(negedge clk);
         #2;
         n++;
      end
      resetn = 1'b0;
      @(negedge clk);
      chk("t4_reset_outputs", 64'({query_x, query_y, x_out, y_out, colour_out, plot,
                                   frame_busy, frame_done, frame_cnt}), 64'(0));
      chk("t4_plots_before_reset", 64'(plots_seen - base), 64'(7));
      exp_q.delete();
      model_cnt = '0;
      #2 resetn = 1'b1;
      repeat (20) @(negedge clk);
      chk("t4_no_done", 64'(done_seen), 64'(4));
      chk("t4_cnt_zero", 64'(frame_cnt), 64'(0));

      // 5: frame_req held high -> back-to-back frames, counter wraps
      dut.frame_cnt = 16'hFFFE;
      model_cnt     = 16'hFFFE;
      base_hit = 4'b0100;
      push_frame(9'h155, 9'h000, 1'b0);
      push_frame(9'h155, 9'h000, 1'b0);
      @(negedge clk);
      frame_req = 1'b1;
      wait_done(6, "t5");
      frame_req = 1'b0;
      chk("t5_period", 64'(last_done_cyc - prev_done_cyc), 64'(16));
      repeat (30) @(negedge clk);
      chk("t5_only_two_frames", 64'(done_seen), 64'(6));
      chk("t5_idle", 64'(frame_busy), 64'(0));
      chk("t5_wrapped", 64'(frame_cnt), 64'(16'h0000));
      chk("t5_queue_empty", 64'(exp_q.size()), 64'(0));

      // 6: every layer hits 9'h007; border override only with VLS_BORDER_EN
      lc0 = 9'h007; lc1 = 9'h007; lc2 = 9'h007; lc3 = 9'h007;
      base_hit = 4'b1111;
      push_frame(9'h007, 9'h000, 1'b0);
      start_frame(1'b0);
      wait_done(7, "t6");
      settle_and_check("t6");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
